imem_loader: RTL
================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter N, default 32, memory word width in bits; the block supports only N=32.
REQ-002 Parameter A, default 32, memory address width in bits.
REQ-003 Parameter SIZE, default 131072, instruction memory capacity in bytes.
REQ-004 Parameter BASE, default 0, byte address of the first word written; BASE SHALL be a multiple of 4.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 start  input  1  one-cycle request to begin a load; honoured only in IDLE or DONE.
REQ-008 in_valid  input  1  byte-stream valid.
REQ-009 in_data  input  8  byte-stream payload.
REQ-010 in_ready  output  1  byte-stream ready; a byte transfers on a cycle with in_valid and in_ready both high.
REQ-011 mem_we  output  1  one-cycle word-write strobe to the instruction memory write port.
REQ-012 mem_addr  output  A  byte address of the write; valid while mem_we is high.
REQ-013 mem_wdata  output  N  little-endian write word; valid while mem_we is high.
REQ-014 busy  output  1  high in LEN and DATA states.
REQ-015 done  output  1  high in DONE state.
REQ-016 err  output  1  high in DONE when the last load was rejected for length.

Function
REQ-017 States: IDLE, LEN, DATA, DONE; the state register is encoded internally.
REQ-018 IDLE or DONE with start=1 -> LEN next cycle; the byte counter and the err flag clear on that transition.
REQ-019 LEN: accept 4 bytes; the first byte accepted is LEN[7:0] and the fourth is LEN[31:24]; LEN is a byte count.
REQ-020 After the 4th length byte: LEN=0 -> DONE with err=0; LEN>SIZE-BASE -> DONE with err=1 and no writes; otherwise -> DATA.
REQ-021 DATA: byte k (0-based) of a word goes to word bits [8k+7:8k].
REQ-022 The cycle after a word's 4th byte is accepted, mem_we=1 for exactly one cycle, with mem_addr=BASE+4*w, where w is the 0-based word index.
REQ-023 If LEN mod 4 != 0, the final partial word is written with unfilled byte lanes set to 0.
REQ-024 The final write is issued the cycle after the LENth byte is accepted; the state enters DONE on the same edge that raises that mem_we.
REQ-025 in_ready=1 in LEN and DATA, except in DATA after the LENth byte; in_ready=0 in IDLE and DONE.
REQ-026 A byte may be accepted in the same cycle mem_we is high, so sustained throughput is 1 byte per cycle.
REQ-027 start while busy=1 is ignored.
REQ-028 start in DONE restarts the load; done and err fall on that edge.
REQ-029 Bytes presented with in_valid while in_ready=0 are not consumed.
REQ-030 The byte counter SHALL be at least 18 bits wide, with no wrap below SIZE.
REQ-031 Write latency from acceptance of a word's last byte to mem_we is 1 cycle.

Reset
REQ-032 On any cycle with rst=1: state is IDLE; in_ready, mem_we, busy, done and err are 0; mem_addr and mem_wdata are 0.
REQ-033 rst has priority over start and in_valid.
REQ-034 Reset mid-load discards the partially assembled word and does not generate a further mem_we.
REQ-035 The first start after rst deasserts is honoured.

Verification
REQ-036 start; bytes 08 00 00 00, then 13 00 00 00 93 00 10 00 -> mem_we at addr 0x0 with wdata 0x00000013, then at addr 0x4 with wdata 0x00100093; done=1; err=0.
REQ-037 start; LEN=5; bytes AA BB CC DD EE -> writes 0xDDCCBBAA at 0x0 and 0x000000EE at 0x4; exactly 2 mem_we pulses.
REQ-038 start; LEN=0x00020004 -> DONE with err=1, zero mem_we pulses, and in_ready=0 afterwards.
REQ-039 LEN=8 with in_valid held high continuously -> 8 data bytes accepted in 8 consecutive cycles; mem_we at cycles +4 and +8 after the first data byte.
REQ-040 rst asserted after 2 data bytes -> no mem_we; all outputs 0; a subsequent start with LEN=4 writes a fresh word at addr 0x0.
REQ-041 start pulsed in DATA -> ignored, and the load completes unchanged; start pulsed in DONE -> busy=1 and done=0 on the next cycle.

Source files
------------

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
// Loads an instruction memory from a byte stream. The stream begins with a
// 4-byte little-endian length (a byte count). The payload bytes that follow
// are packed little-endian into 32-bit words, and each word is written to
// BASE + 4*w.
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   start              begin a load (honoured in IDLE or DONE only)
//   in_valid/in_ready  byte-stream handshake, payload on in_data[7:0]
//   mem_we             one-cycle word write strobe
//   mem_addr/mem_wdata byte address / little-endian word, valid with mem_we
//   busy/done/err      status: loading / finished / length rejected
//
// Only N=32 is supported.
// ---------------------------------------------------------------------------
module imem_loader #(
    parameter int N    = 32,
    parameter int A    = 32,
    parameter int SIZE = 131072,
    parameter int BASE = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         in_valid,
    input  logic [7:0]   in_data,
    output logic         in_ready,
    output logic         mem_we,
    output logic [A-1:0] mem_addr,
    output logic [N-1:0] mem_wdata,
    output logic         busy,
    output logic         done,
    output logic         err
);

    typedef enum logic [1:0] {S_IDLE, S_LEN, S_DATA, S_DONE} state_t;

    // Largest payload that fits between BASE and the end of memory.
    localparam logic [31:0]  CAP    = 32'(SIZE - BASE);
    localparam logic [A-1:0] BASE_A = A'(BASE);

    state_t       state_q, state_d;
    logic [31:0]  cnt_q, cnt_d;      // bytes accepted in the current phase
    logic [31:0]  len_q, len_d;      // payload length being assembled / held
    logic [31:0]  word_q, word_d;    // partially assembled data word
    logic         mem_we_q, mem_we_d;
    logic [A-1:0] addr_q, addr_d;
    logic [31:0]  wdata_q, wdata_d;
    logic         err_q, err_d;

    logic         ready_int;
    logic         accept;
    logic [1:0]   lane;
    logic [31:0]  len_full;
    logic [31:0]  word_nxt;
    logic         last;

    assign ready_int = (state_q == S_LEN) || (state_q == S_DATA);
    assign accept    = in_valid && ready_int;
    assign lane      = cnt_q[1:0];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        len_d    = len_q;
        word_d   = word_q;
        mem_we_d = 1'b0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        err_d    = err_q;

        len_full = len_q;
        len_full[{lane, 3'b000} +: 8] = in_data;
        word_nxt = word_q;
        word_nxt[{lane, 3'b000} +: 8] = in_data;
        last     = (cnt_q + 32'd1) == len_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_LEN;
                    cnt_d   = '0;
                    len_d   = '0;
                    word_d  = '0;
                    err_d   = 1'b0;
                end
            end
            S_LEN: begin
                if (accept) begin
                    len_d = len_full;
                    cnt_d = cnt_q + 32'd1;
                    if (lane == 2'd3) begin
                        cnt_d  = '0;
                        word_d = '0;
                        if (len_full == 32'd0) begin
                            state_d = S_DONE;
                        end else if (len_full > CAP) begin
                            state_d = S_DONE;
                            err_d   = 1'b1;
                        end else begin
                            state_d = S_DATA;
                        end
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    cnt_d  = cnt_q + 32'd1;
                    word_d = word_nxt;
                    // A word is flushed when full or when it holds the final
                    // byte; clearing word_q afterwards zero-fills unused lanes
                    // of a trailing partial word.
                    if (lane == 2'd3 || last) begin
                        mem_we_d = 1'b1;
                        addr_d   = BASE_A + A'({cnt_q[31:2], 2'b00});
                        wdata_d  = word_nxt;
                        word_d   = '0;
                    end
                    if (last) state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            len_q    <= '0;
            word_q   <= '0;
            mem_we_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            len_q    <= len_d;
            word_q   <= word_d;
            mem_we_q <= mem_we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            err_q    <= err_d;
        end
    end

    // Outputs are forced low while rst is high so that no byte is
    // handshaken and no write escapes during the reset cycle itself.
    assign in_ready  = !rst && ready_int;
    assign mem_we    = !rst && mem_we_q;
    assign mem_addr  = rst ? '0 : addr_q;
    assign mem_wdata = rst ? '0 : N'(wdata_q);
    assign busy      = !rst && ready_int;
    assign done      = !rst && (state_q == S_DONE);
    assign err       = !rst && (state_q == S_DONE) && err_q;

endmodule
